// File: rtl/branch_predictor_if.sv
// branch_predictor_if
//   Groups the fetch-side lookup and EX-side training signals of the
//   next-PC predictor into one bundle.
//   master : the pipeline (drives pc_FE and the upd_* training inputs,
//            receives the prediction)
//   slave  : the predictor
//   Signals:
//     pc_FE          current fetch PC
//     pcpred_FE      predicted next fetch PC
//     predtaken_FE   prediction came from a BTB target
//     upd_valid_EX   a branch/JAL resolved this cycle
//     upd_pc_EX      PC of the resolved instruction
//     upd_taken_EX   resolved direction
//     upd_target_EX  resolved taken target
//     upd_mispred_EX pipeline redirected on this instruction
interface branch_predictor_if #(
    parameter int DBITS = 32
);
    logic [DBITS-1:0] pc_FE;
    logic [DBITS-1:0] pcpred_FE;
    logic             predtaken_FE;
    logic             upd_valid_EX;
    logic [DBITS-1:0] upd_pc_EX;
    logic             upd_taken_EX;
    logic [DBITS-1:0] upd_target_EX;
    logic             upd_mispred_EX;

    modport master (
        output pc_FE, upd_valid_EX, upd_pc_EX, upd_taken_EX,
               upd_target_EX, upd_mispred_EX,
        input  pcpred_FE, predtaken_FE
    );

    modport slave (
        input  pc_FE, upd_valid_EX, upd_pc_EX, upd_taken_EX,
               upd_target_EX, upd_mispred_EX,
        output pcpred_FE, predtaken_FE
    );
endinterface

// File: rtl/branch_predictor.sv
// branch_predictor
//   Fetch-stage next-PC predictor: direct-mapped BTB, one 2-bit saturating
//   counter per entry. Lookup is combinational on pc_FE; training from EX
//   is applied at the rising clock edge.
//
//   Ports:
//     clk            pipeline clock
//     RESET_N        synchronous active-low reset (clears all valid bits)
//     bp             branch_predictor_if.slave (lookup + training bundle)
//     stat_resolved  (BP_STATS_EN only) count of resolved branches/JALs
//     stat_mispred   (BP_STATS_EN only) count of redirects
//
//   Configuration macro: BP_STATS_EN -- when defined, adds the two
//   statistics counters and their output ports. Prediction behaviour is
//   identical with or without it.
module branch_predictor #(
    parameter int DBITS      = 32,
    parameter int INSTSIZE   = 4,
    parameter int BTBIDXBITS = 6,
    parameter int TAGBITS    = DBITS - BTBIDXBITS - 2
) (
    input  logic                  clk,
    input  logic                  RESET_N,
    branch_predictor_if.slave     bp
`ifdef BP_STATS_EN
    ,
    output logic [31:0]           stat_resolved,
    output logic [31:0]           stat_mispred
`endif
);
    localparam int NENT = 1 << BTBIDXBITS;

    // Table state. Only valid_q is reset; the rest is qualified by valid.
    logic [NENT-1:0]    valid_q;
    logic [TAGBITS-1:0] tag_q    [NENT];
    logic [DBITS-1:0]   target_q [NENT];
    logic [1:0]         ctr_q    [NENT];

    // ---------------- Lookup ----------------
    logic [BTBIDXBITS-1:0] lk_idx;
    logic [TAGBITS-1:0]    lk_tag;
    logic                  lk_hit;

    assign lk_idx = bp.pc_FE[BTBIDXBITS+1:2];
    assign lk_tag = bp.pc_FE[DBITS-1:BTBIDXBITS+2];
    // Gating with RESET_N makes the reset cycle itself predict PC+4, not
    // just the cycles after the clearing edge.
    assign lk_hit = RESET_N & valid_q[lk_idx] & (tag_q[lk_idx] == lk_tag);

    assign bp.predtaken_FE = lk_hit & ctr_q[lk_idx][1];
    assign bp.pcpred_FE    = bp.predtaken_FE ? target_q[lk_idx]
                                             : bp.pc_FE + DBITS'(INSTSIZE);

    // ---------------- Update ----------------
    logic [BTBIDXBITS-1:0] up_idx;
    logic [TAGBITS-1:0]    up_tag;
    logic                  up_hit;
    logic                  up_we;
    logic [1:0]            up_ctr_d;
    logic [DBITS-1:0]      up_tgt_d;

    assign up_idx = bp.upd_pc_EX[BTBIDXBITS+1:2];
    assign up_tag = bp.upd_pc_EX[DBITS-1:BTBIDXBITS+2];
    assign up_hit = valid_q[up_idx] & (tag_q[up_idx] == up_tag);

    always_comb begin
        up_we    = 1'b0;
        up_ctr_d = ctr_q[up_idx];
        up_tgt_d = target_q[up_idx];
        if (bp.upd_valid_EX) begin
            if (up_hit) begin
                up_we = 1'b1;
                if (bp.upd_taken_EX) begin
                    if (ctr_q[up_idx] != 2'b11) up_ctr_d = ctr_q[up_idx] + 2'd1;
                    up_tgt_d = bp.upd_target_EX;
                end else if (ctr_q[up_idx] != 2'b00) begin
                    up_ctr_d = ctr_q[up_idx] - 2'd1;
                end
            end else if (bp.upd_taken_EX) begin
                // Allocate over whatever lives at this index, weakly taken.
                up_we    = 1'b1;
                up_ctr_d = 2'b10;
                up_tgt_d = bp.upd_target_EX;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!RESET_N) valid_q <= '0;
        else if (up_we) valid_q[up_idx] <= 1'b1;
    end

    // Payload needs no reset; RESET_N still blocks the write so reset wins
    // over a simultaneous update.
    always_ff @(posedge clk) begin
        if (RESET_N && up_we) begin
            tag_q[up_idx]    <= up_tag;
            target_q[up_idx] <= up_tgt_d;
            ctr_q[up_idx]    <= up_ctr_d;
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] stat_resolved_q, stat_resolved_d;
    logic [31:0] stat_mispred_q,  stat_mispred_d;

    always_comb begin
        stat_resolved_d = stat_resolved_q;
        stat_mispred_d  = stat_mispred_q;
        if (bp.upd_valid_EX) begin
            stat_resolved_d = stat_resolved_q + 32'd1;
            if (bp.upd_mispred_EX) stat_mispred_d = stat_mispred_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!RESET_N) begin
            stat_resolved_q <= '0;
            stat_mispred_q  <= '0;
        end else begin
            stat_resolved_q <= stat_resolved_d;
            stat_mispred_q  <= stat_mispred_d;
        end
    end

    assign stat_resolved = stat_resolved_q;
    assign stat_mispred  = stat_mispred_q;

    // Byte-offset bits are always zero for aligned PCs.
    logic unused_bits;
    assign unused_bits = ^{bp.pc_FE[1:0], bp.upd_pc_EX[1:0]};
`else
    // Byte-offset bits are always zero; mispred only feeds the statistics.
    logic unused_bits;
    assign unused_bits = ^{bp.pc_FE[1:0], bp.upd_pc_EX[1:0], bp.upd_mispred_EX};
`endif

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    branch_predictor_if #(.DBITS(32)) bus ();

`ifdef BP_STATS_EN
    logic [31:0] stat_resolved, stat_mispred;
    branch_predictor dut (.clk(clk), .RESET_N(rst_n), .bp(bus.slave),
                          .stat_resolved(stat_resolved), .stat_mispred(stat_mispred));
`else
    branch_predictor dut (.clk(clk), .RESET_N(rst_n), .bp(bus.slave));
`endif

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------- behavioural reference: a table of 64 entries ----------
    bit          m_valid [64];
    int unsigned m_tag   [64];
    int unsigned m_tgt   [64];
    int          m_ctr   [64];
    int unsigned m_res, m_mis;

    function automatic void m_reset();
        for (int i = 0; i < 64; i++) m_valid[i] = 0;
        m_res = 0; m_mis = 0;
    endfunction

    function automatic int unsigned m_pred(input int unsigned pc);
        int unsigned idx = (pc / 4) % 64;
        int unsigned tag = pc / 256;
        if (m_valid[idx] && m_tag[idx] == tag && m_ctr[idx] >= 2) return m_tgt[idx];
        return pc + 4; // unsigned 32-bit wrap
    endfunction

    function automatic void m_update(input int unsigned pc, input bit taken,
                                     input int unsigned tgt, input bit mis);
        int unsigned idx = (pc / 4) % 64;
        int unsigned tag = pc / 256;
        m_res++;
        if (mis) m_mis++;
        if (m_valid[idx] && m_tag[idx] == tag) begin
            if (taken) begin
                m_ctr[idx] = (m_ctr[idx] + 1 > 3) ? 3 : m_ctr[idx] + 1;
                m_tgt[idx] = tgt;
            end else begin
                m_ctr[idx] = (m_ctr[idx] - 1 < 0) ? 0 : m_ctr[idx] - 1;
            end
        end else if (taken) begin
            m_valid[idx] = 1; m_tag[idx] = tag; m_tgt[idx] = tgt; m_ctr[idx] = 2;
        end
    endfunction

    // ---------- directed vectors: update + lookup in the same cycle ----------
    typedef struct {
        string       name;
        bit          uv;
        logic [31:0] upc;
        bit          utk;
        logic [31:0] utgt;
        logic [31:0] lpc;
        logic [31:0] exp_pred;
        bit          exp_tk;
    } vec_t;

    vec_t vecs[$];

    function automatic void addv(input string n, input bit uv, input logic [31:0] upc,
                                 input bit utk, input logic [31:0] utgt,
                                 input logic [31:0] lpc, input logic [31:0] ep, input bit et);
        vec_t v;
        v.name = n; v.uv = uv; v.upc = upc; v.utk = utk; v.utgt = utgt;
        v.lpc = lpc; v.exp_pred = ep; v.exp_tk = et;
        vecs.push_back(v);
    endfunction

    task automatic drive_idle();
        bus.upd_valid_EX = 0; bus.upd_pc_EX = 0; bus.upd_taken_EX = 0;
        bus.upd_target_EX = 0; bus.upd_mispred_EX = 0;
    endtask

    // Inputs change at posedge+1, outputs sampled at posedge+4.
    task automatic cycle();
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 0;
        bus.pc_FE = 32'h100;
        drive_idle();
        m_reset();
        cycle();
        rst_n = 1;
        #3;
        chk("cold_reset_pred", bus.pcpred_FE, 32'h104);
        chk("cold_reset_tk", {31'b0, bus.predtaken_FE}, 32'h0);

        // lookup sees the pre-update contents of the same cycle
        addv("lookup_0x100",   0, 0,      0, 0,      32'h100, 32'h104, 0);
        addv("alloc_samecyc",  1, 32'h120, 1, 32'h200, 32'h120, 32'h124, 0);
        addv("alloc_visible",  0, 0,      0, 0,      32'h120, 32'h200, 1);
        addv("nt_from_2",      1, 32'h120, 0, 0,      32'h120, 32'h200, 1);
        addv("ctr1_pred",      0, 0,      0, 0,      32'h120, 32'h124, 0);
        addv("tk_from_1",      1, 32'h120, 1, 32'h200, 32'h120, 32'h124, 0);
        addv("tk_from_2",      1, 32'h120, 1, 32'h200, 32'h120, 32'h200, 1);
        addv("nt_from_3",      1, 32'h120, 0, 0,      32'h120, 32'h200, 1);
        addv("hyst_holds",     0, 0,      0, 0,      32'h120, 32'h200, 1);
        addv("alias_miss",     0, 0,      0, 0,      32'h220, 32'h224, 0);
        addv("alias_alloc",    1, 32'h220, 1, 32'h300, 32'h220, 32'h224, 0);
        addv("alias_evicted",  0, 0,      0, 0,      32'h120, 32'h124, 0);
        addv("alias_new",      0, 0,      0, 0,      32'h220, 32'h300, 1);
        addv("same_cycle_old", 1, 32'h140, 1, 32'h500, 32'h140, 32'h144, 0);
        addv("same_cycle_new", 0, 0,      0, 0,      32'h140, 32'h500, 1);
        addv("wrap",           0, 0,      0, 0,      32'hFFFFFFFC, 32'h0, 0);
        addv("miss_nt_upd",    1, 32'h160, 0, 32'h700, 32'h160, 32'h164, 0);
        addv("miss_nt_noalloc",0, 0,      0, 0,      32'h160, 32'h164, 0);

        foreach (vecs[i]) begin
            bus.upd_valid_EX = vecs[i].uv; bus.upd_pc_EX = vecs[i].upc;
            bus.upd_taken_EX = vecs[i].utk; bus.upd_target_EX = vecs[i].utgt;
            bus.upd_mispred_EX = 0;
            bus.pc_FE = vecs[i].lpc;
            #3;
            chk({vecs[i].name, "_pred"}, bus.pcpred_FE, vecs[i].exp_pred);
            chk({vecs[i].name, "_tk"}, {31'b0, bus.predtaken_FE}, {31'b0, vecs[i].exp_tk});
            cycle();
        end
        drive_idle();

        // reset with a simultaneous allocating update: reset wins, and the
        // lookup during the reset cycle already shows PC+4
        rst_n = 0;
        bus.upd_valid_EX = 1; bus.upd_pc_EX = 32'h1C0; bus.upd_taken_EX = 1;
        bus.upd_target_EX = 32'h900;
        bus.pc_FE = 32'h140;
        #3;
        chk("during_reset_pred", bus.pcpred_FE, 32'h144);
        cycle();
        rst_n = 1; drive_idle();
        #3;
        chk("post_reset_0x140", bus.pcpred_FE, 32'h144);
        bus.pc_FE = 32'h1C0; #1;
        chk("reset_beats_upd", bus.pcpred_FE, 32'h1C4);
        cycle();

`ifdef BP_STATS_EN
        // stats: counters start at 0 after reset
        chk("stat_res_reset", stat_resolved, 0);
        chk("stat_mis_reset", stat_mispred, 0);
        for (int k = 0; k < 5; k++) begin
            bus.upd_valid_EX = 1; bus.upd_pc_EX = 32'h400 + 32'(k * 4);
            bus.upd_taken_EX = k[0]; bus.upd_target_EX = 32'h800;
            bus.upd_mispred_EX = (k == 1 || k == 3);
            cycle();
        end
        drive_idle();
        // an idle cycle must not count
        cycle();
        chk("stat_res_5", stat_resolved, 5);
        chk("stat_mis_2", stat_mispred, 2);
        rst_n = 0; cycle(); rst_n = 1;
        chk("stat_res_clr", stat_resolved, 0);
        chk("stat_mis_clr", stat_mispred, 0);
`endif

        // ---------- randomized run against the reference model ----------
        rst_n = 0; drive_idle(); cycle(); rst_n = 1;
        m_reset();
        for (int n = 0; n < 1500; n++) begin
            int unsigned lpc, upc, tgt;
            bit uv, tk, mis, do_rst;
            // small PC pool: 8 indices x 4 tags so hits and aliases are common
            lpc = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2);
            upc = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2);
            if ($urandom_range(0, 19) == 0) lpc = 32'hFFFFFFFC;
            tgt = $urandom() & 32'hFFFFFFFC;
            uv = $urandom_range(0, 1);
            tk = ($urandom_range(0, 3) != 0);
            mis = $urandom_range(0, 1);
            do_rst = ($urandom_range(0, 199) == 0);
            rst_n = !do_rst;
            bus.pc_FE = lpc; bus.upd_valid_EX = uv; bus.upd_pc_EX = upc;
            bus.upd_taken_EX = tk; bus.upd_target_EX = tgt; bus.upd_mispred_EX = mis;
            #3;
            chk("rand_pred", bus.pcpred_FE, do_rst ? lpc + 4 : m_pred(lpc));
            chk("rand_tk", {31'b0, bus.predtaken_FE},
                {31'b0, (!do_rst && m_pred(lpc) != lpc + 4)});
            cycle();
            if (do_rst) m_reset();
            else if (uv) m_update(upc, tk, tgt, mis);
`ifdef BP_STATS_EN
            chk("rand_stat_res", stat_resolved, m_res);
            chk("rand_stat_mis", stat_mispred, m_mis);
`endif
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
